// File: rtl/datapath_ctrl.sv
// Micro-sequencer for the datapath block: accepts one instruction per handshake and
// steps FETCH/E1/E2/PCINC. Define CTRL_BRANCH_EN to enable BRZ (opcode 0xB).
module datapath_ctrl #(
  parameter int unsigned M = 3,
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic         z_flag,
  output logic         busy,
  output logic         illegal,
  output logic         ie,
  output logic         write,
  output logic         reada,
  output logic         readb,
  output logic         en,
  output logic         oe,
  output logic         bypassa,
  output logic         bypassb,
  output logic         mov_sel,
  output logic [2:0]   op,
  output logic [M-1:0] waddr,
  output logic [M-1:0] ra,
  output logic [M-1:0] rb,
  output logic [N-1:0] offset
);

  localparam logic [M-1:0] PC_ADDR = '1;
  localparam logic [3:0]   OPC_RMAX = 4'h5;
  localparam logic [3:0]   OPC_LDI  = 4'h8;
  localparam logic [3:0]   OPC_ST   = 4'h9;
  localparam logic [3:0]   OPC_NOP  = 4'hA;
  localparam logic [3:0]   OPC_BRZ  = 4'hB;
  localparam logic [3:0]   OPC_IN   = 4'hC;
  localparam logic [2:0]   ALU_MOV  = 3'b110;
  localparam logic [2:0]   ALU_INC  = 3'b111;

  typedef enum logic [1:0] {FETCH, E1, E2, PCINC} state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        zl_d;

`ifdef CTRL_BRANCH_EN
  logic        zl_q;
`else
  logic        unused_z;
  assign unused_z = z_flag;
`endif

  // State, IR and latched zero flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
`ifdef CTRL_BRANCH_EN
      zl_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
`ifdef CTRL_BRANCH_EN
      zl_q    <= zl_d;
`endif
    end
  end

  // Next-state: accept in FETCH, then walk the per-class micro-steps
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
`ifdef CTRL_BRANCH_EN
    zl_d    = zl_q;
`else
    zl_d    = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        if (instr_valid && instr_ready) begin
          ir_d = instr;
`ifdef CTRL_BRANCH_EN
          zl_d = z_flag;
`endif
          if (instr[15:12] <= OPC_RMAX) begin
            state_d = E1;
          end else begin
            case (instr[15:12])
              OPC_LDI, OPC_ST, OPC_IN: state_d = E1;
`ifdef CTRL_BRANCH_EN
              OPC_BRZ: state_d = z_flag ? E1 : PCINC;
`endif
              default: state_d = PCINC;
            endcase
          end
        end
      end
      E1: begin
        if (ir_q[15:12] <= OPC_RMAX || ir_q[15:12] == OPC_ST) begin
          state_d = E2;
`ifdef CTRL_BRANCH_EN
        end else if (ir_q[15:12] == OPC_BRZ) begin
          state_d = FETCH;
`endif
        end else begin
          state_d = PCINC;
        end
      end
      E2:      state_d = PCINC;
      PCINC:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  logic [3:0]   opc_d;
  logic         legal_d;
  logic         ready_n, busy_n, illegal_n, ie_n, write_n, reada_n, readb_n;
  logic         en_n, oe_n, bypassa_n, bypassb_n, mov_sel_n;
  logic [2:0]   op_n;
  logic [M-1:0] waddr_n, ra_n, rb_n;
  logic [N-1:0] offset_n;

  assign opc_d = ir_d[15:12];

  always_comb begin
    legal_d = (opc_d <= OPC_RMAX) || (opc_d == OPC_LDI) || (opc_d == OPC_ST) ||
              (opc_d == OPC_NOP) || (opc_d == OPC_IN);
`ifdef CTRL_BRANCH_EN
    legal_d = legal_d || (opc_d == OPC_BRZ);
`endif
  end

  // Control decode of the upcoming state, registered so outputs see no input paths
  always_comb begin
    ready_n   = 1'b0;
    busy_n    = (state_d != FETCH);
    illegal_n = 1'b0;
    ie_n      = 1'b0;
    write_n   = 1'b0;
    reada_n   = 1'b0;
    readb_n   = 1'b0;
    en_n      = 1'b0;
    oe_n      = 1'b0;
    bypassa_n = 1'b0;
    bypassb_n = 1'b0;
    mov_sel_n = 1'b0;
    op_n      = '0;
    waddr_n   = '0;
    ra_n      = '0;
    rb_n      = '0;
    offset_n  = '0;
    case (state_d)
      FETCH: ready_n = 1'b1;
      E1, E2: begin
        if (opc_d <= OPC_RMAX) begin
          reada_n = 1'b1;
          readb_n = 1'b1;
          ra_n    = M'(ir_d[8:6]);
          rb_n    = M'(ir_d[5:3]);
          op_n    = opc_d[2:0];
          if (state_d == E2) begin
            en_n    = 1'b1;
            write_n = 1'b1;
            waddr_n = M'(ir_d[11:9]);
          end
        end else begin
          case (opc_d)
            OPC_LDI: begin
              bypassa_n = 1'b1;
              bypassb_n = 1'b1;
              en_n      = 1'b1;
              write_n   = 1'b1;
              op_n      = ALU_MOV;
              waddr_n   = M'(ir_d[11:9]);
              offset_n  = N'($signed(ir_d[5:0]));
            end
            OPC_ST: begin
              reada_n   = 1'b1;
              ra_n      = M'(ir_d[8:6]);
              en_n      = 1'b1;
              oe_n      = 1'b1;
              bypassb_n = 1'b1;
              op_n      = ALU_MOV;
              if (state_d == E2) begin
                readb_n   = 1'b1;
                rb_n      = M'(ir_d[5:3]);
                mov_sel_n = 1'b1;
              end
            end
            OPC_IN: begin
              ie_n    = 1'b1;
              write_n = 1'b1;
              waddr_n = M'(ir_d[11:9]);
            end
`ifdef CTRL_BRANCH_EN
            OPC_BRZ: begin
              if (zl_d) begin
                reada_n   = 1'b1;
                ra_n      = PC_ADDR;
                bypassb_n = 1'b1;
                op_n      = 3'b000;
                offset_n  = N'($signed(ir_d[5:0]));
                en_n      = 1'b1;
                write_n   = 1'b1;
                oe_n      = 1'b1;
                waddr_n   = PC_ADDR;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      PCINC: begin
        illegal_n = !legal_d;
        reada_n   = 1'b1;
        ra_n      = PC_ADDR;
        bypassb_n = 1'b1;
        en_n      = 1'b1;
        write_n   = 1'b1;
        oe_n      = 1'b1;
        op_n      = ALU_INC;
        waddr_n   = PC_ADDR;
      end
      default: ;
    endcase
  end

  // Output registers; all zero while in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      illegal     <= 1'b0;
      ie          <= 1'b0;
      write       <= 1'b0;
      reada       <= 1'b0;
      readb       <= 1'b0;
      en          <= 1'b0;
      oe          <= 1'b0;
      bypassa     <= 1'b0;
      bypassb     <= 1'b0;
      mov_sel     <= 1'b0;
      op          <= '0;
      waddr       <= '0;
      ra          <= '0;
      rb          <= '0;
      offset      <= '0;
    end else begin
      instr_ready <= ready_n;
      busy        <= busy_n;
      illegal     <= illegal_n;
      ie          <= ie_n;
      write       <= write_n;
      reada       <= reada_n;
      readb       <= readb_n;
      en          <= en_n;
      oe          <= oe_n;
      bypassa     <= bypassa_n;
      bypassb     <= bypassb_n;
      mov_sel     <= mov_sel_n;
      op          <= op_n;
      waddr       <= waddr_n;
      ra          <= ra_n;
      rb          <= rb_n;
      offset      <= offset_n;
    end
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: per-cycle expected control vectors are queued
// when an instruction is issued and compared at each falling edge.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst, instr_valid, z_flag;
  logic [15:0] instr;
  logic        instr_ready, busy, illegal, ie, write, reada, readb;
  logic        en, oe, bypassa, bypassb, mov_sel;
  logic [2:0]  op, waddr, ra, rb;
  logic [7:0]  offset;

  always #5 clk = ~clk;

  datapath_ctrl #(.M(3), .N(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .z_flag(z_flag), .busy(busy), .illegal(illegal),
    .ie(ie), .write(write), .reada(reada), .readb(readb), .en(en), .oe(oe),
    .bypassa(bypassa), .bypassb(bypassb), .mov_sel(mov_sel), .op(op),
    .waddr(waddr), .ra(ra), .rb(rb), .offset(offset)
  );

  typedef struct packed {
    logic       ready, busy, illegal, ie, write, reada, readb, en, oe;
    logic       bypassa, bypassb, mov_sel;
    logic [2:0] op, waddr, ra, rb;
    logic [7:0] offset;
  } ctl_t;

  ctl_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic ctl_t observe();
    ctl_t c;
    c = '{instr_ready, busy, illegal, ie, write, reada, readb, en, oe,
          bypassa, bypassb, mov_sel, op, waddr, ra, rb, offset};
    return c;
  endfunction

  function automatic ctl_t c_fetch();
    ctl_t c = '0;
    c.ready = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_busy();
    ctl_t c = '0;
    c.busy = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_pcinc(input logic ill);
    ctl_t c = c_busy();
    c.illegal = ill; c.reada = 1'b1; c.ra = 3'd7; c.bypassb = 1'b1; c.en = 1'b1;
    c.write = 1'b1; c.oe = 1'b1; c.op = 3'b111; c.waddr = 3'd7;
    return c;
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] o, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {o, rd, rs1, rs2, 3'b000};
  endfunction

  // Present one instruction at a FETCH falling edge; return at the first busy cycle
  task automatic issue(input logic [15:0] i, input logic z);
    instr = i; instr_valid = 1'b1; z_flag = z;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    ctl_t obs;
    rst = 1'b1; instr_valid = 1'b1; instr = mk(4'h0, 3'd1, 3'd2, 3'd3); z_flag = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== ctl_t'('0)) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got %h want %h", k, obs, ctl_t'('0));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    obs = observe();
    checks++;
    if (obs !== c_fetch()) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", obs, c_fetch());
    end
  endtask

  task automatic test_rtype(input logic [3:0] o, input logic [2:0] rd,
                            input logic [2:0] rs1, input logic [2:0] rs2);
    ctl_t e, obs;
    e = c_busy(); e.reada = 1'b1; e.readb = 1'b1; e.ra = rs1; e.rb = rs2; e.op = o[2:0];
    exp_q.push_back(e);
    e.en = 1'b1; e.write = 1'b1; e.waddr = rd;
    exp_q.push_back(e);
    exp_q.push_back(c_pcinc(1'b0));
    exp_q.push_back(c_fetch());
    issue(mk(o, rd, rs1, rs2), 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rtype op%0h: got %h want %h", o, obs, e);
      end
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_ldi(input logic [2:0] rd, input logic [5:0] imm, input logic [7:0] sx);
    ctl_t e, obs;
    e = c_busy(); e.bypassa = 1'b1; e.bypassb = 1'b1; e.en = 1'b1; e.write = 1'b1;
    e.op = 3'b110; e.waddr = rd; e.offset = sx;
    exp_q.push_back(e);
    exp_q.push_back(c_pcinc(1'b0));
    exp_q.push_back(c_fetch());
    issue({4'h8, rd, 3'b101, imm}, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL ldi imm %h: got %h want %h", imm, obs, e);
      end
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_st(input logic [2:0] rs1, input logic [2:0] rs2);
    ctl_t e, obs;
    e = c_busy(); e.reada = 1'b1; e.ra = rs1; e.en = 1'b1; e.oe = 1'b1;
    e.bypassb = 1'b1; e.op = 3'b110; e.mov_sel = 1'b0;
    exp_q.push_back(e);
    e.readb = 1'b1; e.rb = rs2; e.mov_sel = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(c_pcinc(1'b0));
    exp_q.push_back(c_fetch());
    issue(mk(4'h9, 3'd4, rs1, rs2), 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL st: got %h want %h", obs, e);
      end
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_in_nop();
    ctl_t e, obs;
    e = c_busy(); e.ie = 1'b1; e.write = 1'b1; e.waddr = 3'd6;
    exp_q.push_back(e);
    exp_q.push_back(c_pcinc(1'b0));
    exp_q.push_back(c_fetch());
    issue(mk(4'hC, 3'd6, 3'd1, 3'd2), 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL in: got %h want %h", obs, e);
      end
      if (exp_q.size() > 0) @(negedge clk);
    end
    exp_q.push_back(c_pcinc(1'b0));
    exp_q.push_back(c_fetch());
    issue(mk(4'hA, 3'd3, 3'd3, 3'd3), 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL nop: got %h want %h", obs, e);
      end
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    ctl_t e, obs;
    logic [3:0] bad [5] = '{4'h6, 4'h7, 4'hD, 4'hE, 4'hF};
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(c_pcinc(1'b1));
      exp_q.push_back(c_fetch());
      issue(mk(bad[k], 3'd2, 3'd5, 3'd1), 1'b0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); obs = observe(); checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL illegal op%0h: got %h want %h", bad[k], obs, e);
        end
        if (exp_q.size() > 0) @(negedge clk);
      end
    end
  endtask

  // Valid held high across an illegal op: the LDI is taken only once back in FETCH
  task automatic test_back_to_back();
    ctl_t e, obs;
    exp_q.push_back(c_pcinc(1'b1));
    exp_q.push_back(c_fetch());
    e = c_busy(); e.bypassa = 1'b1; e.bypassb = 1'b1; e.en = 1'b1; e.write = 1'b1;
    e.op = 3'b110; e.waddr = 3'd3; e.offset = 8'h15;
    exp_q.push_back(e);
    exp_q.push_back(c_pcinc(1'b0));
    exp_q.push_back(c_fetch());
    instr = mk(4'hF, 3'd0, 3'd0, 3'd0); instr_valid = 1'b1; z_flag = 1'b0;
    @(negedge clk);
    instr = {4'h8, 3'd3, 3'd0, 6'h15};
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %h want %h", k, obs, e);
      end
      if (k == 1) begin
        @(negedge clk);
        instr_valid = 1'b0;
      end else if (exp_q.size() > 0) begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_abort();
    ctl_t obs;
    issue(mk(4'h2, 3'd5, 3'd6, 3'd7), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    obs = observe(); checks++;
    if (obs !== ctl_t'('0)) begin
      failures++;
      $display("FAIL abort_reset: got %h want %h", obs, ctl_t'('0));
    end
    rst = 1'b0;
    @(negedge clk);
    obs = observe(); checks++;
    if (obs !== c_fetch()) begin
      failures++;
      $display("FAIL abort_release: got %h want %h", obs, c_fetch());
    end
  endtask

  task automatic test_branch();
    ctl_t e, obs;
`ifdef CTRL_BRANCH_EN
    e = c_busy(); e.reada = 1'b1; e.ra = 3'd7; e.bypassb = 1'b1; e.op = 3'b000;
    e.offset = 8'h02; e.en = 1'b1; e.write = 1'b1; e.oe = 1'b1; e.waddr = 3'd7;
    exp_q.push_back(e);
    exp_q.push_back(c_fetch());
    exp_q.push_back(c_pcinc(1'b0));
    exp_q.push_back(c_fetch());
`else
    exp_q.push_back(c_pcinc(1'b1));
    exp_q.push_back(c_fetch());
    exp_q.push_back(c_pcinc(1'b1));
    exp_q.push_back(c_fetch());
`endif
    issue({4'hB, 3'd0, 3'd0, 6'h02}, 1'b1);
    z_flag = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL brz_z1 cycle %0d: got %h want %h", k, obs, e);
      end
      if (k == 0) @(negedge clk);
    end
    issue({4'hB, 3'd0, 3'd0, 6'h02}, 1'b0);
    z_flag = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(); checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL brz_z0: got %h want %h", obs, e);
      end
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype(4'h0, 3'd1, 3'd0, 3'd1);
    test_rtype(4'h3, 3'd4, 3'd6, 3'd2);
    test_rtype(4'h5, 3'd7, 3'd3, 3'd5);
    test_ldi(3'd5, 6'h3C, 8'hFC);
    test_ldi(3'd2, 6'h05, 8'h05);
    test_st(3'd2, 3'd3);
    test_in_nop();
    test_illegal();
    test_back_to_back();
    test_abort();
    test_branch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
